data_mem_responder: RTL and testbench

// - Memory-side responder for the CPU data port: serves mem_rd/mem_wr at ram_addr with data_mem_in/data_mem_out.
// - 0x000-0xEFF: word RAM. 0xF00-0xFFF: MMIO with GPIO, a 16-bit timer, and a TX stream FIFO.
// - Sits beside the CPU in the top level, opposite the CPU data-memory pins. Instruction memory is out of scope.

---
 rtl/microcpu_mem_pkg.sv | 56 +++++
 rtl/data_mem_responder_if.sv | 11 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/microcpu_mem_pkg.sv
// Shared address map, register bit positions and address decode for the
// CPU data-port responder.
package microcpu_mem_pkg;

  localparam logic [11:0] MMIO_BASE     = 12'hF00;
  localparam logic [11:0] ADDR_GPIO_OUT = 12'hF00;
  localparam logic [11:0] ADDR_GPIO_IN  = 12'hF01;
  localparam logic [11:0] ADDR_TMR_CNT  = 12'hF02;
  localparam logic [11:0] ADDR_TMR_CMP  = 12'hF03;
  localparam logic [11:0] ADDR_STATUS   = 12'hF04;
  localparam logic [11:0] ADDR_TX_DATA  = 12'hF05;
  localparam logic [11:0] ADDR_CTRL     = 12'hF06;

  localparam int ST_MATCH = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam int CTRL_TMR_EN   = 0;
  localparam int CTRL_AUTO_CLR = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_TMR_CNT,
    SEL_TMR_CMP,
    SEL_STATUS,
    SEL_TX_DATA,
    SEL_CTRL
  } sel_e;

  // Holes below MMIO_BASE beyond the RAM, and unused MMIO slots, decode to SEL_NONE.
  function automatic sel_e decode_addr(input logic [11:0] addr, input int ram_words);
    sel_e sel;
    sel = SEL_NONE;
    if (addr < MMIO_BASE) begin
      if (int'(addr) < ram_words) sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_GPIO_OUT: sel = SEL_GPIO_OUT;
        ADDR_GPIO_IN:  sel = SEL_GPIO_IN;
        ADDR_TMR_CNT:  sel = SEL_TMR_CNT;
        ADDR_TMR_CMP:  sel = SEL_TMR_CMP;
        ADDR_STATUS:   sel = SEL_STATUS;
        ADDR_TX_DATA:  sel = SEL_TX_DATA;
        ADDR_CTRL:     sel = SEL_CTRL;
        default:       sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [11:0] ram_addr;
  logic [15:0] data_mem_in;
  logic [15:0] data_mem_out;

  modport master (output mem_rd, mem_wr, ram_addr, data_mem_in, input data_mem_out);
  modport slave  (input mem_rd, mem_wr, ram_addr, data_mem_in, output data_mem_out);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word; a push while full
// is accepted only if a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             do_push, do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = head_reg;

  always_comb begin
    do_pop      = pop && !empty;
    do_push     = push && (!full || do_pop);
    drop        = push && !do_push;
    rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg + CW'(do_push) - CW'(do_pop);
    // The new head bypasses storage when the incoming word lands right at it.
    if (count_next == '0)
      head_next = '0;
    else if (do_push && (wr_ptr_reg == rd_ptr_next))
      head_next = din;
    else
      head_next = mem_reg[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM below 0xF00, MMIO block (GPIO, 16-bit timer,
// TX stream FIFO) above it. Reads are combinational, writes land on the edge.
module data_mem_responder
  import microcpu_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 3840,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  data_mem_responder_if.slave    bus,
  input  logic [15:0]            gpio_in,
  output logic [15:0]            gpio_out,
  output logic [15:0]            tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   irq
);
  logic [15:0] ram [RAM_WORDS];

  sel_e        sel;
  logic [15:0] gpio_meta_reg, gpio_sync_reg, gpio_out_reg;
  logic [15:0] tmr_cnt_reg, tmr_cnt_next, tmr_cmp_reg, tmr_inc;
  logic [2:0]  ctrl_reg;
  logic        match_reg, ovf_reg, match_next, ovf_next;
  logic        cnt_wr, tmr_hit, status_rd;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [15:0] status_word;

  assign sel       = decode_addr(bus.ram_addr, RAM_WORDS);
  assign cnt_wr    = bus.mem_wr && (sel == SEL_TMR_CNT);
  assign status_rd = bus.mem_rd && (sel == SEL_STATUS);
  assign fifo_push = bus.mem_wr && (sel == SEL_TX_DATA);
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;
  assign gpio_out  = gpio_out_reg;
  assign irq       = match_reg && ctrl_reg[CTRL_IRQ_EN];

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.data_mem_in),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .count (fifo_count)
  );

  // A CPU load of the count takes priority over counting and never raises match.
  always_comb begin
    tmr_inc      = tmr_cnt_reg + 16'd1;
    tmr_hit      = ctrl_reg[CTRL_TMR_EN] && !cnt_wr && (tmr_inc == tmr_cmp_reg);
    tmr_cnt_next = tmr_cnt_reg;
    if (cnt_wr)
      tmr_cnt_next = bus.data_mem_in;
    else if (ctrl_reg[CTRL_TMR_EN])
      tmr_cnt_next = (tmr_hit && ctrl_reg[CTRL_AUTO_CLR]) ? 16'd0 : tmr_inc;
    match_next = tmr_hit   || (match_reg && !status_rd);
    ovf_next   = fifo_drop || (ovf_reg && !status_rd);
  end

  always_comb begin
    status_word          = '0;
    status_word[ST_MATCH] = match_reg;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_OVF]   = ovf_reg;
    status_word[7:4]      = 4'(fifo_count);
  end

  always_comb begin
    bus.data_mem_out = '0;
    if (bus.mem_rd) begin
      case (sel)
        SEL_RAM:      bus.data_mem_out = ram[bus.ram_addr];
        SEL_GPIO_OUT: bus.data_mem_out = gpio_out_reg;
        SEL_GPIO_IN:  bus.data_mem_out = gpio_sync_reg;
        SEL_TMR_CNT:  bus.data_mem_out = tmr_cnt_reg;
        SEL_TMR_CMP:  bus.data_mem_out = tmr_cmp_reg;
        SEL_STATUS:   bus.data_mem_out = status_word;
        SEL_CTRL:     bus.data_mem_out = {13'd0, ctrl_reg};
        default:      bus.data_mem_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bus.mem_wr && (sel == SEL_RAM)) ram[bus.ram_addr] <= bus.data_mem_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_meta_reg <= '0;
      gpio_sync_reg <= '0;
      gpio_out_reg  <= '0;
      tmr_cnt_reg   <= '0;
      tmr_cmp_reg   <= '0;
      ctrl_reg      <= '0;
      match_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      gpio_meta_reg <= gpio_in;
      gpio_sync_reg <= gpio_meta_reg;
      if (bus.mem_wr && (sel == SEL_GPIO_OUT)) gpio_out_reg <= bus.data_mem_in;
      if (bus.mem_wr && (sel == SEL_TMR_CMP))  tmr_cmp_reg  <= bus.data_mem_in;
      if (bus.mem_wr && (sel == SEL_CTRL))     ctrl_reg     <= bus.data_mem_in[2:0];
      tmr_cnt_reg <= tmr_cnt_next;
      match_reg   <= match_next;
      ovf_reg     <= ovf_next;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus queues expected read/TX words, two monitors
// pop and compare whenever the DUT presents a read or a TX handshake.
module tb_data_mem_responder;
  import microcpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpio_in, gpio_out, tx_data;
  logic        tx_valid, tx_ready, irq;

  data_mem_responder_if bus ();

  data_mem_responder #(.RAM_WORDS(3840), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t tx_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  task automatic push_exp(inout exp_t q[$], input string name, input logic [15:0] exp);
    exp_t t;
    t.name = name;
    t.exp  = exp;
    q.push_back(t);
  endtask

  // Each bus op occupies exactly one clock cycle, driven from just after an edge.
  task automatic op(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] d);
    bus.mem_rd      = rd;
    bus.mem_wr      = wr;
    bus.ram_addr    = a;
    bus.data_mem_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    op(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [11:0] a, input logic [15:0] exp, input string name);
    push_exp(rd_q, name, exp);
    op(1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic idle(input int n);
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Read-data monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.mem_rd === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%04h, expected no read", bus.data_mem_out);
      end else begin
        e = rd_q.pop_front();
        check(e.name, bus.data_mem_out, e.exp);
      end
    end
  end

  // TX stream monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%04h, expected no word", tx_data);
      end else begin
        e = tx_q.pop_front();
        check(e.name, tx_data, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [15:0] cnt_exp [7];
    cnt_exp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1};

    reset           = 1'b1;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.ram_addr    = '0;
    bus.data_mem_in = '0;
    gpio_in         = '0;
    tx_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio_out", gpio_out, 16'h0000);
    check("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    check("rst_tx_data", tx_data, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b0;

    rd(ADDR_STATUS, 16'h0004, "status_reset");
    rd(ADDR_CTRL, 16'h0000, "ctrl_reset");
    rd(ADDR_TMR_CNT, 16'h0000, "tmr_cnt_reset");

    // RAM and unmapped space
    wr(12'h010, 16'h1234);
    wr(12'hEFF, 16'hBEEF);
    rd(12'h010, 16'h1234, "ram_010");
    rd(12'hEFF, 16'hBEEF, "ram_eff");
    rd(12'hF08, 16'h0000, "unmapped_f08");
    rd(ADDR_TX_DATA, 16'h0000, "tx_data_reads_0");
    push_exp(rd_q, "rdwr_prewrite", 16'h1234);
    op(1'b1, 1'b1, 12'h010, 16'h5555);
    rd(12'h010, 16'h5555, "ram_after_rdwr");

    // GPIO
    wr(ADDR_GPIO_OUT, 16'hA5A5);
    check("gpio_out_next", gpio_out, 16'hA5A5);
    rd(ADDR_GPIO_OUT, 16'hA5A5, "gpio_out_rb");
    gpio_in = 16'h00FF;
    rd(ADDR_GPIO_IN, 16'h0000, "gpio_in_e0");
    rd(ADDR_GPIO_IN, 16'h0000, "gpio_in_e1");
    rd(ADDR_GPIO_IN, 16'h00FF, "gpio_in_e2");

    // Timer: cmp=5, enable with auto_clr and irq_en
    wr(ADDR_TMR_CMP, 16'd5);
    wr(ADDR_CTRL, 16'h0007);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("irq_cyc%0d", i), {15'd0, irq}, (i >= 5) ? 16'h0001 : 16'h0000);
      rd(ADDR_TMR_CNT, cnt_exp[i], $sformatf("tmr_cnt_cyc%0d", i));
    end
    wr(ADDR_CTRL, 16'h0000);
    check("irq_masked", {15'd0, irq}, 16'h0000);
    rd(ADDR_STATUS, 16'h0005, "status_match");
    rd(ADDR_STATUS, 16'h0004, "status_match_cleared");

    wr(ADDR_CTRL, 16'h0001);
    wr(ADDR_TMR_CNT, 16'd5);
    rd(ADDR_TMR_CNT, 16'd5, "tmr_cnt_load");
    rd(ADDR_STATUS, 16'h0004, "tmr_load_no_match");
    wr(ADDR_TMR_CNT, 16'hFFFF);
    rd(ADDR_TMR_CNT, 16'hFFFF, "tmr_pre_wrap");
    rd(ADDR_TMR_CNT, 16'h0000, "tmr_wrap");
    wr(ADDR_CTRL, 16'h0000);

    // FIFO fill past full, then push+pop while full, then drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) push_exp(tx_q, $sformatf("tx_word%0d", i), 16'(i));
      wr(ADDR_TX_DATA, 16'(i));
    end
    check("tx_valid_full", {15'd0, tx_valid}, 16'h0001);
    check("tx_head_held", tx_data, 16'h0001);
    rd(ADDR_STATUS, 16'h008A, "status_full_ovf");
    check("tx_head_still_held", tx_data, 16'h0001);
    push_exp(tx_q, "tx_word_aa", 16'h00AA);
    tx_ready = 1'b1;
    wr(ADDR_TX_DATA, 16'h00AA);
    tx_ready = 1'b0;
    rd(ADDR_STATUS, 16'h0082, "status_full_pushpop");
    tx_ready = 1'b1;
    k = 0;
    while (k < 20 && tx_valid === 1'b1) begin
      idle(1);
      k++;
    end
    tx_ready = 1'b0;
    check("tx_drained_valid", {15'd0, tx_valid}, 16'h0000);
    check("tx_q_consumed", 16'(tx_q.size()), 16'h0000);

    // Asynchronous reset mid-stream
    wr(ADDR_TX_DATA, 16'h0011);
    wr(ADDR_TX_DATA, 16'h0022);
    wr(ADDR_TX_DATA, 16'h0033);
    wr(ADDR_GPIO_OUT, 16'h5A5A);
    wr(12'h020, 16'hCAFE);
    wr(ADDR_TMR_CNT, 16'd0);
    wr(ADDR_TMR_CMP, 16'd2);
    wr(ADDR_CTRL, 16'h0005);
    idle(3);
    check("irq_before_reset", {15'd0, irq}, 16'h0001);
    check("tx_valid_before_reset", {15'd0, tx_valid}, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check("async_tx_valid", {15'd0, tx_valid}, 16'h0000);
    check("async_tx_data", tx_data, 16'h0000);
    check("async_gpio_out", gpio_out, 16'h0000);
    check("async_irq", {15'd0, irq}, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(12'h020, 16'hCAFE, "ram_survives_reset");
    rd(ADDR_STATUS, 16'h0004, "status_after_reset");
    rd(ADDR_CTRL, 16'h0000, "ctrl_after_reset");
    idle(2);

    check("rd_q_consumed", 16'(rd_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
